gate_edge_counter: RTL and testbench
====================================

GATE_EDGE_COUNTER -- requirements
Module: gate_edge_counter

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 24, which is the width of the edge count and the result.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, which is the number of flip-flops in the input synchronizer (legal range 2..4).
REQ-003 SHALL have port clock, input, 1 bit: system clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port gate_tick, input, 1 bit: one-cycle strobe in the clock domain that marks the boundary of a measurement window.
REQ-006 SHALL have port signal_in, input, 1 bit: signal under measurement, asynchronous to clock.
REQ-007 SHALL have port result_ready, input, 1 bit: the consumer accepts the result.
REQ-008 SHALL have port freq_count, output, COUNT_WIDTH bits: latched edge count of the last completed window.
REQ-009 SHALL have port result_valid, output, 1 bit: freq_count holds an unconsumed result.
REQ-010 SHALL have port overflow, output, 1 bit: the window count saturated; latched with freq_count.
REQ-011 SHALL have port overrun, output, 1 bit: the previous result was overwritten before it was consumed; latched with freq_count.

Function
REQ-012 SHALL pass signal_in through a SYNC_STAGES flip-flop synchronizer, followed by one registered stage for edge detection.
REQ-013 SHALL count a rising edge exactly SYNC_STAGES+1 cycles after the transition at signal_in; the edge detector SHALL need one cycle high after one cycle low.
REQ-014 SHALL have a state machine with two states:
- IDLE (after reset): edges are not counted; the first gate_tick moves it to COUNT with the counter at 0 and nothing latched.
- COUNT: each detected edge increments the counter.
REQ-015 SHALL, on gate_tick in COUNT, load the counter value (including any edge detected in that same cycle) into freq_count, set result_valid, and restart the counter at 0 in the next cycle.
REQ-016 SHALL saturate the counter at 2^COUNT_WIDTH-1 and set an internal window-overflow bit; at latch time that bit SHALL be copied to overflow and then cleared.
REQ-017 SHALL hold result_valid and freq_count stable until a cycle in which result_valid=1 and result_ready=1; result_valid SHALL clear in the following cycle.
REQ-018 SHALL, on gate_tick while result_valid=1 and result_ready=0, overwrite freq_count, keep result_valid=1, and set overrun=1.
REQ-019 SHALL, on gate_tick in the same cycle as result_valid=1 and result_ready=1, load the new result, keep result_valid=1, and set overrun=0.
REQ-020 SHALL, on any clean latch (no pending result), set overrun=0.
REQ-021 SHALL ignore result_ready while result_valid=0.
REQ-022 SHALL treat back-to-back gate_tick on consecutive cycles as valid windows; the second window latches a count of 0 or 1.

Reset
REQ-023 SHALL, while reset=1 (asynchronously), hold freq_count=0, result_valid=0, overflow=0, overrun=0, counter=0, the synchronizer and edge registers at 0, and the state at IDLE.
REQ-024 SHALL, on reset asserted mid-window, discard the partial count; after release the block SHALL wait in IDLE for the next gate_tick.
REQ-025 SHALL NOT treat signal_in high at reset release as an edge.

Configuration
REQ-026 SHALL use the macro BOTH_EDGES_EN: when defined, both rising and falling synchronized edges increment the counter (result = 2 x frequency x window); when undefined, only rising edges count.
REQ-027 SHALL keep latency, handshake and saturation rules identical in both builds.

Verification
REQ-028 Reset, gate_tick, then 10 rising edges, then gate_tick -> freq_count=10, result_valid=1, overflow=0, overrun=0.
REQ-029 Edge synchronized in the same cycle as the closing gate_tick -> counted in the closing window (11 for 10+1), and the next window starts at 0.
REQ-030 COUNT_WIDTH=4 with 20 edges in a window -> freq_count=15, overflow=1; the next window with 3 edges -> freq_count=3, overflow=0.
REQ-031 result_ready held 0 across two gate_ticks (5 edges, then 7) -> freq_count=7, overrun=1, result_valid=1; ready pulse -> result_valid=0 next cycle.
REQ-032 reset pulsed after 6 edges mid-window, then gate_tick, 4 edges, gate_tick -> freq_count=4; outputs at 0 during reset.
REQ-033 BOTH_EDGES_EN defined with 8 full input periods in a window -> freq_count=16; undefined -> freq_count=8.

Source files
------------

// File: rtl/gate_edge_counter.sv
// Gated edge counter: counts synchronized edges of signal_in between gate_tick strobes.
// Define BOTH_EDGES_EN to count falling as well as rising edges.
module gate_edge_counter #(
    parameter int COUNT_WIDTH = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   gate_tick,
    input  logic                   signal_in,
    input  logic                   result_ready,
    output logic [COUNT_WIDTH-1:0] freq_count,
    output logic                   result_valid,
    output logic                   overflow,
    output logic                   overrun
);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t                 stateQ, stateD;
    logic [SYNC_STAGES-1:0] syncQ;
    logic [SYNC_STAGES-1:0] fillQ;
    logic                   edgeQ;
    logic                   armQ;
    logic [COUNT_WIDTH-1:0] cntQ, cntD;
    logic                   ovfWinQ, ovfWinD;
    logic [COUNT_WIDTH-1:0] freqQ, freqD;
    logic                   validQ, validD;
    logic                   ovfQ, ovfD;
    logic                   ovrQ, ovrD;

    logic                   syncOut;
    logic                   riseHit;
    logic                   edgeHit;
    logic                   atMax;
    logic [COUNT_WIDTH-1:0] cntNext;
    logic                   ovfNext;

    // fillQ tracks which synchronizer stages hold real samples rather than reset zeros;
    // armQ is only set once a genuine low has been seen, so a high level at reset
    // release can never look like a rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            syncQ <= '0;
            fillQ <= '0;
            edgeQ <= 1'b0;
            armQ  <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], signal_in};
            fillQ <= {fillQ[SYNC_STAGES-2:0], 1'b1};
            edgeQ <= syncOut;
            if (fillQ[SYNC_STAGES-1] && !syncOut) begin
                armQ <= 1'b1;
            end
        end
    end

    assign syncOut = syncQ[SYNC_STAGES-1];
    assign riseHit = syncOut & ~edgeQ & armQ;

`ifdef BOTH_EDGES_EN
    assign edgeHit = riseHit | (~syncOut & edgeQ);
`else
    assign edgeHit = riseHit;
`endif

    assign atMax   = &cntQ;
    assign cntNext = (edgeHit && !atMax) ? cntQ + COUNT_WIDTH'(1) : cntQ;
    assign ovfNext = ovfWinQ | (edgeHit & atMax);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateQ  <= IDLE;
            cntQ    <= '0;
            ovfWinQ <= 1'b0;
            freqQ   <= '0;
            validQ  <= 1'b0;
            ovfQ    <= 1'b0;
            ovrQ    <= 1'b0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            ovfWinQ <= ovfWinD;
            freqQ   <= freqD;
            validQ  <= validD;
            ovfQ    <= ovfD;
            ovrQ    <= ovrD;
        end
    end

    // A latch includes the edge seen in the closing cycle; a latch always wins over a
    // same-cycle consume, with overrun flagging an unconsumed result being replaced.
    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        ovfWinD = ovfWinQ;
        freqD   = freqQ;
        validD  = validQ;
        ovfD    = ovfQ;
        ovrD    = ovrQ;

        if (validQ && result_ready) begin
            validD = 1'b0;
        end

        case (stateQ)
            IDLE: begin
                if (gate_tick) begin
                    stateD  = COUNT;
                    cntD    = '0;
                    ovfWinD = 1'b0;
                end
            end
            COUNT: begin
                cntD    = cntNext;
                ovfWinD = ovfNext;
                if (gate_tick) begin
                    freqD   = cntNext;
                    ovfD    = ovfNext;
                    validD  = 1'b1;
                    ovrD    = validQ & ~result_ready;
                    cntD    = '0;
                    ovfWinD = 1'b0;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    assign freq_count   = freqQ;
    assign result_valid = validQ;
    assign overflow     = ovfQ;
    assign overrun      = ovrQ;

endmodule

// File: tb/tb_gate_edge_counter.sv
// Self-checking bench for gate_edge_counter: a wide and a 4-bit instance share stimulus
// and are compared every cycle against a sample-history model, plus literal expectations.
module tb_gate_edge_counter;

    localparam int N    = 2;
    localparam int MAXW = (1 << 24) - 1;
    localparam int MAXN = 15;
`ifdef BOTH_EDGES_EN
    localparam int EM = 2;
`else
    localparam int EM = 1;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        gate_tick;
    logic        signal_in;
    logic        result_ready;
    logic [23:0] fcW;
    logic        vW, ofW, orW;
    logic [3:0]  fcN;
    logic        vN, ofN, orN;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    typedef struct {
        bit counting;
        int cnt;
        bit ovfWin;
        int fc;
        bit valid;
        bit ovf;
        bit ovr;
    } ModelT;

    ModelT mW, mN;
    bit    hist[$];
    int    k;
    bit    hit;

    gate_edge_counter #(.COUNT_WIDTH(24), .SYNC_STAGES(N)) dut (
        .clock(clock), .reset(reset), .gate_tick(gate_tick), .signal_in(signal_in),
        .result_ready(result_ready), .freq_count(fcW), .result_valid(vW),
        .overflow(ofW), .overrun(orW)
    );

    gate_edge_counter #(.COUNT_WIDTH(4), .SYNC_STAGES(N)) dutNarrow (
        .clock(clock), .reset(reset), .gate_tick(gate_tick), .signal_in(signal_in),
        .result_ready(result_ready), .freq_count(fcN), .result_valid(vN),
        .overflow(ofN), .overrun(orN)
    );

    always #5 clock = ~clock;

    function automatic ModelT clearModel();
        ModelT m;
        m.counting = 0; m.cnt = 0; m.ovfWin = 0; m.fc = 0;
        m.valid = 0; m.ovf = 0; m.ovr = 0;
        return m;
    endfunction

    function automatic ModelT stepModel(ModelT m, int maxV, bit edgeSeen, bit g, bit r);
        ModelT n = m;
        int    c;
        bit    o;
        if (m.valid && r) n.valid = 0;
        if (!m.counting) begin
            if (g) begin
                n.counting = 1; n.cnt = 0; n.ovfWin = 0;
            end
        end else begin
            c = m.cnt;
            o = m.ovfWin;
            if (edgeSeen) begin
                if (c == maxV) o = 1;
                else c = c + 1;
            end
            if (g) begin
                n.fc = c; n.ovf = o; n.valid = 1; n.ovr = m.valid && !r;
                n.cnt = 0; n.ovfWin = 0;
            end else begin
                n.cnt = c; n.ovfWin = o;
            end
        end
        return n;
    endfunction

    // An edge is counted N samples after it appears at the input, and only between
    // two samples both taken since the last reset release.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            hist.delete();
            mW = clearModel();
            mN = clearModel();
        end else begin
            hist.push_back(signal_in);
            k   = hist.size();
            hit = 0;
            if (k >= N + 2) begin
`ifdef BOTH_EDGES_EN
                hit = hist[k-N-1] != hist[k-N-2];
`else
                hit = hist[k-N-1] && !hist[k-N-2];
`endif
            end
            mW = stepModel(mW, MAXW, hit, gate_tick, result_ready);
            mN = stepModel(mN, MAXN, hit, gate_tick, result_ready);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== 32'(expected)) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("fcW", 32'(fcW), mW.fc);
            checkOutput("validW", 32'(vW), int'(mW.valid));
            checkOutput("overflowW", 32'(ofW), int'(mW.ovf));
            checkOutput("overrunW", 32'(orW), int'(mW.ovr));
            checkOutput("fcN", 32'(fcN), mN.fc);
            checkOutput("validN", 32'(vN), int'(mN.valid));
            checkOutput("overflowN", 32'(ofN), int'(mN.ovf));
            checkOutput("overrunN", 32'(orN), int'(mN.ovr));
        end
    end

    task automatic applyStimulus(input logic g, input logic s, input logic r);
        @(negedge clock);
        #1;
        gate_tick    = g;
        signal_in    = s;
        result_ready = r;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic setReset(input logic v, input logic s);
        @(negedge clock);
        #1;
        reset        = v;
        signal_in    = s;
        gate_tick    = 1'b0;
        result_ready = 1'b0;
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_fc"}, 32'(fcW), 0);
        checkOutput({tag, "_valid"}, 32'(vW), 0);
        checkOutput({tag, "_overflow"}, 32'(ofW), 0);
        checkOutput({tag, "_overrun"}, 32'(orW), 0);
    endtask

    initial begin
        reset        = 1'b1;
        gate_tick    = 1'b0;
        signal_in    = 1'b0;
        result_ready = 1'b0;
        repeat (3) @(negedge clock);
        setReset(1'b0, 1'b0);
        checkEn = 1'b1;
        checkZeroOutputs("reset");

        // Basic window of ten rising edges.
        idle(3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        pulses(10);
        idle(5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("basic_fc", 32'(fcW), 10 * EM);
        checkOutput("basic_valid", 32'(vW), 1);
        checkOutput("basic_overflow", 32'(ofW), 0);
        checkOutput("basic_overrun", 32'(orW), 0);

        // Edge reaches the counter in the closing cycle; tick coincides with ready.
        pulses(10);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("closing_edge_fc", 32'(fcW), 10 * EM + 1);
        checkOutput("closing_edge_valid", 32'(vW), 1);
        checkOutput("closing_edge_overrun", 32'(orW), 0);
        idle(4);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("next_window_fc", 32'(fcW), EM - 1);

        // Back-to-back ticks.
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("b2b_fc", 32'(fcW), 0);
        checkOutput("b2b_valid", 32'(vW), 1);

        // Saturation on the narrow instance, then a clean window.
        applyStimulus(1'b1, 1'b0, 1'b1);
        pulses(20);
        idle(5);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("sat_fc", 32'(fcN), 15);
        checkOutput("sat_overflow", 32'(ofN), 1);
        checkOutput("sat_wide_fc", 32'(fcW), 20 * EM);
        pulses(3);
        idle(5);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("post_sat_fc", 32'(fcN), 3 * EM);
        checkOutput("post_sat_overflow", 32'(ofN), 0);

        // Overrun: two latches without a consume.
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        pulses(5);
        idle(5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        pulses(7);
        idle(5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("overrun_fc", 32'(fcW), 7 * EM);
        checkOutput("overrun_flag", 32'(orW), 1);
        checkOutput("overrun_valid", 32'(vW), 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("consume_valid", 32'(vW), 0);
        checkOutput("consume_fc_held", 32'(fcW), 7 * EM);

        // Reset mid-window with signal_in high through release.
        applyStimulus(1'b1, 1'b0, 1'b0);
        pulses(6);
        setReset(1'b1, 1'b1);
        #1;
        checkZeroOutputs("midreset");
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        setReset(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
        idle(2);
        pulses(4);
        idle(5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("after_reset_fc", 32'(fcW), (EM == 2) ? 9 : 4);

        // Eight full input periods.
        applyStimulus(1'b1, 1'b0, 1'b1);
        pulses(8);
        idle(5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("eight_periods_fc", 32'(fcW), 8 * EM);

        idle(2);
        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
